rsa_exp_sequencer: RTL and testbench

- Synthesizable controller that runs one full 4096-bit modular exponentiation with no testbench involvement.
- Sequences the precompute units:
  - rtMod mode 0 produces T.
  - rtMod mode 1 produces R.
  - modInv produces nprime0.
- Streams m/e/n/r/t word-serially into ModExp, waits for COMPLETE, then reassembles the result word-serially.
- Caches R/T/nprime0 per modulus, so repeated operations under the same key skip precompute.

---
 rtl/rsa_exp_sequencer.sv | 164 ++++++++++++++++
 tb/tb_rsa_exp_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_exp_sequencer.sv
// rsa_exp_sequencer: runs precompute (T, R, n'0) with a per-key cache, then streams one modexp through ModExp.
module rsa_exp_sequencer #(
  parameter int WIDTH       = 4096,
  parameter int DATA_WIDTH  = 64,
  parameter int NWORDS      = WIDTH / DATA_WIDTH,
  parameter int COMPLETE_ST = 9,
  parameter int TIMEOUT     = 1 << 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      message,
  input  logic [WIDTH-1:0]      exponent,
  input  logic [WIDTH-1:0]      modulus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WIDTH-1:0]      result,
  output logic                  rt_go,
  output logic                  rt_mode,
  input  logic [WIDTH-1:0]      rt_out,
  input  logic                  rt_done,
  output logic                  inv_go,
  input  logic [63:0]           inv_out,
  input  logic                  inv_valid,
  output logic [DATA_WIDTH-1:0] m_buf,
  output logic [DATA_WIDTH-1:0] e_buf,
  output logic [DATA_WIDTH-1:0] n_buf,
  output logic [DATA_WIDTH-1:0] r_buf,
  output logic [DATA_WIDTH-1:0] t_buf,
  output logic [63:0]           nprime0,
  output logic                  start_input,
  output logic                  start_compute,
  output logic                  get_result,
  input  logic [4:0]            exp_state,
  input  logic [DATA_WIDTH-1:0] res_out
);
  localparam int KW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] LAST = KW'(NWORDS - 1);
  localparam logic [WDW-1:0] TO_LAST = WDW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, CALC_T, CALC_R, CALC_N0, SEND, COMPUTE, READ, DONE} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [WDW-1:0] wd;
  logic [WIDTH-1:0] key_reg, r_reg, t_reg, acc, acc_n;
  logic cache_valid, wait_st;
  assign wait_st = state inside {CALC_T, CALC_R, CALC_N0, COMPUTE};
  // word slices are only driven while loading so the buses idle at zero
  assign m_buf = start_input ? message[int'(k)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign e_buf = start_input ? exponent[int'(k)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign n_buf = start_input ? modulus[int'(k)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign r_buf = start_input ? r_reg[int'(k)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign t_buf = start_input ? t_reg[int'(k)*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_comb begin
    acc_n = acc;
    acc_n[int'(k)*DATA_WIDTH +: DATA_WIDTH] = res_out;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      wd <= '0;
      key_reg <= '0;
      r_reg <= '0;
      t_reg <= '0;
      acc <= '0;
      cache_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      result <= '0;
      rt_go <= 1'b0;
      rt_mode <= 1'b0;
      inv_go <= 1'b0;
      nprime0 <= '0;
      start_input <= 1'b0;
      start_compute <= 1'b0;
      get_result <= 1'b0;
    end else begin
      rt_go <= 1'b0;
      inv_go <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      wd <= wait_st ? wd + 1'b1 : '0;
      case (state)
        IDLE: if (start) begin
          key_reg <= modulus;
          busy <= 1'b1;
          k <= '0;
          if (cache_valid && modulus == key_reg) begin
            state <= SEND;
            start_input <= 1'b1;
          end else begin
            cache_valid <= 1'b0;
            state <= CALC_T;
            rt_go <= 1'b1;
            rt_mode <= 1'b0;
          end
        end
        CALC_T: if (rt_done && !rt_go) begin
          t_reg <= rt_out;
          state <= CALC_R;
          rt_go <= 1'b1;
          rt_mode <= 1'b1;
          wd <= '0;
        end
        CALC_R: if (rt_done && !rt_go) begin
          r_reg <= rt_out;
          state <= CALC_N0;
          inv_go <= 1'b1;
          wd <= '0;
        end
        CALC_N0: if (inv_valid && !inv_go) begin
          nprime0 <= inv_out;
          cache_valid <= 1'b1;
          state <= SEND;
          start_input <= 1'b1;
          k <= '0;
        end
        SEND: if (k == LAST) begin
          start_input <= 1'b0;
          start_compute <= 1'b1;
          get_result <= 1'b1;
          k <= '0;
          state <= COMPUTE;
        end else k <= k + 1'b1;
        COMPUTE: if (exp_state == 5'(COMPLETE_ST)) begin
          state <= READ;
          k <= '0;
          wd <= '0;
        end
        READ: begin
          acc <= acc_n;
          if (k == LAST) begin
            result <= acc_n;
            start_compute <= 1'b0;
            get_result <= 1'b0;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else k <= k + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      // watchdog abort overrides any transition taken in the same cycle
      if (wait_st && wd == TO_LAST) begin
        done <= 1'b1;
        error <= 1'b1;
        busy <= 1'b0;
        cache_valid <= 1'b0;
        rt_go <= 1'b0;
        rt_mode <= 1'b0;
        inv_go <= 1'b0;
        start_input <= 1'b0;
        start_compute <= 1'b0;
        get_result <= 1'b0;
        wd <= '0;
        state <= DONE;
      end
    end
  end
endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// tb_rsa_exp_sequencer: directed scoreboard bench with rtMod/modInv stubs and a small ModExp model.
module tb_rsa_exp_sequencer;
  localparam int W = 4096, DW = 64, NW = 64, TO = 1000;
  logic clk = 0, reset = 1, start = 0;
  logic [W-1:0] message = '0, exponent = '0, modulus = '0;
  logic [W-1:0] result, rt_out, tv, rv;
  logic busy, done, error, rt_go, rt_mode, rt_done, inv_go, inv_valid;
  logic start_input, start_compute, get_result;
  logic [63:0] inv_out, nprime0;
  logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, res_out;
  logic [4:0] exp_state;
  always #5 clk = ~clk;

  rsa_exp_sequencer #(.WIDTH(W), .DATA_WIDTH(DW), .NWORDS(NW), .COMPLETE_ST(9), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .message(message), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .error(error), .result(result),
    .rt_go(rt_go), .rt_mode(rt_mode), .rt_out(rt_out), .rt_done(rt_done),
    .inv_go(inv_go), .inv_out(inv_out), .inv_valid(inv_valid),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
    .nprime0(nprime0), .start_input(start_input), .start_compute(start_compute),
    .get_result(get_result), .exp_state(exp_state), .res_out(res_out));

  typedef struct {logic [W-1:0] res; logic err; logic [63:0] np;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int checks = 0, failures = 0, done_cnt = 0, rt_go_cnt = 0, inv_go_cnt = 0, widx = 0;
  logic [7:0] modes = '0;
  bit rt_hang = 0;

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got low word %0h expected low word %0h (upper words differ: %0b)",
               nm, act[63:0], exp[63:0], act[W-1:64] !== exp[W-1:64]);
    end
  endtask

  function automatic logic [63:0] powmod(input logic [63:0] b, input logic [63:0] e, input logic [63:0] n);
    logic [127:0] r, x;
    r = 128'd1;
    x = 128'(b) % 128'(n);
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % 128'(n);
      x = (x * x) % 128'(n);
    end
    return r[63:0];
  endfunction

  assign tv = modulus + W'(1);
  assign rv = modulus + W'(2);

  // rtMod / modInv stubs with 20-cycle latency
  int rt_cnt, inv_cnt;
  logic rt_m;
  always @(posedge clk) begin
    if (reset) begin
      rt_cnt <= 0; inv_cnt <= 0; rt_done <= 0; inv_valid <= 0; rt_out <= '0; inv_out <= '0; rt_m <= 0;
    end else begin
      rt_done <= 0;
      inv_valid <= 0;
      if (rt_go) begin rt_cnt <= 20; rt_m <= rt_mode; end
      else if (rt_cnt > 0) rt_cnt <= rt_cnt - 1;
      if (rt_cnt == 1 && !rt_hang) begin rt_done <= 1; rt_out <= rt_m ? rv : tv; end
      if (inv_go) inv_cnt <= 20;
      else if (inv_cnt > 0) inv_cnt <= inv_cnt - 1;
      if (inv_cnt == 1) begin inv_valid <= 1; inv_out <= 64'hABCD_0000_0000_0000 ^ modulus[63:0]; end
    end
  end

  // ModExp model: gathers word 0, COMPLETE after 30 cycles, then streams result words
  logic [63:0] mm, ee, nn;
  int sidx, ecnt, ridx;
  logic cmp;
  always @(posedge clk) begin
    if (reset) begin
      sidx <= 0; ecnt <= 0; ridx <= 0; cmp <= 0; exp_state <= '0; res_out <= '0;
      mm <= '0; ee <= '0; nn <= 64'd1;
    end else begin
      if (start_input && sidx == 0) begin mm <= m_buf; ee <= e_buf; nn <= n_buf; end
      sidx <= start_input ? sidx + 1 : 0;
      if (!start_compute) begin
        ecnt <= 0; ridx <= 0; cmp <= 0; exp_state <= '0;
      end else begin
        ecnt <= ecnt + 1;
        if (!cmp) exp_state <= 5'd3;
        if (ecnt == 30) begin exp_state <= 5'd9; cmp <= 1; ridx <= 0; end
        if (cmp) begin
          res_out <= (ridx == 0) ? powmod(mm, ee, nn) : '0;
          ridx <= ridx + 1;
        end
      end
    end
  end

  // word-stream checker
  always @(negedge clk) begin
    if (start_input) begin
      check64("send_m", m_buf, message[widx*DW +: DW]);
      check64("send_e", e_buf, exponent[widx*DW +: DW]);
      check64("send_n", n_buf, modulus[widx*DW +: DW]);
      check64("send_r", r_buf, rv[widx*DW +: DW]);
      check64("send_t", t_buf, tv[widx*DW +: DW]);
      widx++;
    end else if (widx != 0) begin
      check64("send_count", 64'(widx), 64'(NW));
      widx = 0;
    end
  end

  // scoreboard monitor and pulse counters
  always @(negedge clk) begin
    if (error) check64("error_with_done", 64'(done), 64'd1);
    if (done) begin
      done_cnt++;
      check64("busy_at_done", 64'(busy), 64'd0);
      if (sb.size() == 0) check64("unexpected_done", 64'(done), 64'd0);
      else begin
        cur = sb.pop_front();
        checkw("result", result, cur.res);
        check64("error", 64'(error), 64'(cur.err));
        check64("nprime0", nprime0, cur.np);
      end
    end
    if (rt_go) begin rt_go_cnt++; modes = {modes[6:0], rt_mode}; end
    if (inv_go) inv_go_cnt++;
  end

  function automatic logic [63:0] npv(input logic [63:0] n);
    return 64'hABCD_0000_0000_0000 ^ n;
  endfunction

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic set_op(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n);
    message = W'(m);
    exponent = W'(e);
    modulus = W'(n);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 20000) begin @(negedge clk); lat++; end
    check64("done_seen", 64'(done), 64'd1);
  endtask

  task automatic do_op(input logic [63:0] m, input logic [63:0] e, input logic [63:0] n,
                       input logic [63:0] r, input bit pre, output int lat);
    int rt0, inv0;
    set_op(m, e, n);
    sb.push_back('{W'(r), 1'b0, npv(n)});
    rt0 = rt_go_cnt;
    inv0 = inv_go_cnt;
    pulse_start();
    check64("busy_after_start", 64'(busy), 64'd1);
    wait_done(lat);
    @(negedge clk);
    check64("rt_go_pulses", 64'(rt_go_cnt - rt0), pre ? 64'd2 : 64'd0);
    check64("inv_go_pulses", 64'(inv_go_cnt - inv0), pre ? 64'd1 : 64'd0);
    if (pre) check64("rt_mode_order", 64'(modes[1:0]), 64'd1);
  endtask

  task automatic wait_rt_go();
    int w = 0;
    while (!rt_go && w < 1000) begin @(negedge clk); w++; end
    check64("rt_go_seen", 64'(rt_go), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    check64({tag, "_busy"}, 64'(busy), 64'd0);
    check64({tag, "_done"}, 64'(done), 64'd0);
    check64({tag, "_ctrl"}, 64'({rt_go, rt_mode, inv_go, start_input, start_compute, get_result, error}), 64'd0);
    check64({tag, "_nprime0"}, nprime0, 64'd0);
    check64({tag, "_bufs"}, m_buf | e_buf | n_buf | r_buf | t_buf, 64'd0);
    checkw({tag, "_result"}, result, '0);
  endtask

  initial begin
    int lat1, lat2, lat, d0, rt0, cnt;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 0;
    @(negedge clk);
    do_op(8, 13, 77, 50, 1, lat1);
    do_op(2, 10, 77, 23, 0, lat2);
    check64("cached_faster", 64'(lat2 + 60 < lat1), 64'd1);
    do_op(8, 13, 91, 8, 1, lat);
    // start while busy is dropped
    set_op(8, 13, 77);
    sb.push_back('{W'(50), 1'b0, npv(77)});
    d0 = done_cnt;
    rt0 = rt_go_cnt;
    pulse_start();
    wait_rt_go();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(lat);
    repeat (100) @(negedge clk);
    check64("single_done", 64'(done_cnt - d0), 64'd1);
    check64("busy_rt_go_pulses", 64'(rt_go_cnt - rt0), 64'd2);
    check64("idle_after_busy_start", 64'(busy), 64'd0);
    // watchdog in CALC_T
    rt_hang = 1;
    set_op(8, 13, 91);
    sb.push_back('{W'(50), 1'b1, npv(77)});
    pulse_start();
    wait_rt_go();
    cnt = 0;
    while (!done && cnt < 3000) begin @(negedge clk); cnt++; end
    check64("timeout_cycles", 64'(cnt), 64'(TO));
    @(negedge clk);
    rt_hang = 0;
    do_op(8, 13, 91, 8, 1, lat);
    // reset while reading word 30
    set_op(2, 10, 77);
    sb.push_back('{W'(23), 1'b0, npv(77)});
    pulse_start();
    cnt = 0;
    while (exp_state != 5'd9 && cnt < 1000) begin @(negedge clk); cnt++; end
    check64("complete_seen", 64'(exp_state), 64'd9);
    repeat (31) @(negedge clk);
    reset = 1;
    void'(sb.pop_back());
    @(negedge clk);
    check_zero("abort");
    reset = 0;
    d0 = done_cnt;
    repeat (150) @(negedge clk);
    check64("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    do_op(2, 10, 77, 23, 1, lat);
    check64("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
